// File: rtl/spi_stream_tx_pkg.sv
// Shared types and constants for the FIFO-buffered SPI stream transmitter.
package spi_stream_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_STALL = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

  localparam logic SPI_IDLE_SCLK = 1'b1;
  localparam int   FIFO_WIDTH    = 9;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/spi_stream_tx_fifo.sv
// Synchronous FIFO whose registered read port always presents the current head entry,
// so a consumer can pop and use the data in the same cycle.
module sync_fifo
  import spi_stream_tx_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      rd_ptr_nxt_s;
  logic [WIDTH-1:0] rd_data_r;
  logic             push_s;
  logic             pop_s;

  assign full         = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty        = (wr_ptr_r == rd_ptr_r);
  assign push_s       = wr_en & ~full;
  assign pop_s        = rd_en & ~empty;
  assign rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
  assign rd_data      = rd_data_r;

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers and head register; a write landing in the next head slot bypasses the array.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      rd_data_r <= '0;
    end else begin
      wr_ptr_r  <= wr_ptr_r + {{AW{1'b0}}, push_s};
      rd_ptr_r  <= rd_ptr_nxt_s;
      if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
        rd_data_r <= wr_data;
      end else begin
        rd_data_r <= mem_r[rd_ptr_nxt_s[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spi_stream_tx.sv
// FIFO-buffered SPI master (mode 3 style, sclk idle high): shifts framed byte streams
// out MSB-first, keeps ss low across a frame and returns each byte captured from miso.
module spi_stream_tx
  import spi_stream_tx_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CS_GAP     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_state_e  state_r, state_nxt_s;
  logic [DW-1:0] div_r, div_nxt_s;
  logic [2:0]  bit_r, bit_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic [7:0]  tx_sh_r, tx_sh_nxt_s;
  logic [7:0]  rx_sh_r, rx_sh_nxt_s;
  logic        last_r, last_nxt_s;
  logic        ss_r, ss_nxt_s;
  logic        sclk_r, sclk_nxt_s;
  logic        mosi_r, mosi_nxt_s;
  logic [7:0]  rx_data_r, rx_data_nxt_s;
  logic        rx_valid_r, rx_valid_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        pop_s, push_s, full_s, empty_s, div_end_s;
  fifo_entry_t head_s;

  sync_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (in_valid),
    .wr_data ({in_last, in_data}),
    .rd_en   (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign push_s    = in_valid & ~full_s;
  assign div_end_s = (div_r == DIV_LAST);
  assign in_ready  = ~full_s;
  assign ss        = ss_r;
  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign busy      = busy_r;

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    div_nxt_s      = div_r;
    bit_nxt_s      = bit_r;
    gap_nxt_s      = gap_r;
    tx_sh_nxt_s    = tx_sh_r;
    rx_sh_nxt_s    = rx_sh_r;
    last_nxt_s     = last_r;
    ss_nxt_s       = ss_r;
    sclk_nxt_s     = sclk_r;
    mosi_nxt_s     = mosi_r;
    rx_data_nxt_s  = rx_data_r;
    rx_valid_nxt_s = 1'b0;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          tx_sh_nxt_s = head_s.data;
          last_nxt_s  = head_s.last;
          mosi_nxt_s  = head_s.data[7];
          ss_nxt_s    = 1'b0;
          div_nxt_s   = '0;
          bit_nxt_s   = 3'd0;
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_end_s) begin
          div_nxt_s   = '0;
          sclk_nxt_s  = 1'b0;
          state_nxt_s = ST_SHIFT;
        end else begin
          div_nxt_s = div_r + DW'(1);
        end
      end
      ST_SHIFT: begin
        if (!div_end_s) begin
          div_nxt_s = div_r + DW'(1);
        end else begin
          div_nxt_s = '0;
          if (!sclk_r) begin
            sclk_nxt_s  = 1'b1;
            rx_sh_nxt_s = {rx_sh_r[6:0], miso};
          end else if (bit_r != 3'd7) begin
            sclk_nxt_s  = 1'b0;
            bit_nxt_s   = bit_r + 3'd1;
            tx_sh_nxt_s = {tx_sh_r[6:0], 1'b0};
            mosi_nxt_s  = tx_sh_r[6];
          end else begin
            // Byte complete: hand over the capture, then chain, stall or close the frame.
            bit_nxt_s      = 3'd0;
            rx_data_nxt_s  = rx_sh_r;
            rx_valid_nxt_s = 1'b1;
            if (last_r) begin
              state_nxt_s = ST_HOLD;
            end else if (!empty_s) begin
              pop_s       = 1'b1;
              tx_sh_nxt_s = head_s.data;
              last_nxt_s  = head_s.last;
              mosi_nxt_s  = head_s.data[7];
              sclk_nxt_s  = 1'b0;
            end else begin
              state_nxt_s = ST_STALL;
            end
          end
        end
      end
      ST_STALL: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          tx_sh_nxt_s = head_s.data;
          last_nxt_s  = head_s.last;
          mosi_nxt_s  = head_s.data[7];
          div_nxt_s   = '0;
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      ST_HOLD: begin
        if (div_end_s) begin
          div_nxt_s   = '0;
          gap_nxt_s   = '0;
          ss_nxt_s    = 1'b1;
          mosi_nxt_s  = 1'b0;
          state_nxt_s = ST_GAP;
        end else begin
          div_nxt_s = div_r + DW'(1);
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_nxt_s   = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s = gap_r + GW'(1);
        end
      end
      default: begin
        ss_nxt_s    = 1'b1;
        sclk_nxt_s  = SPI_IDLE_SCLK;
        mosi_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE) | ~empty_s | push_s;
  end

  // State, counters, shift registers and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      div_r      <= '0;
      bit_r      <= 3'd0;
      gap_r      <= '0;
      tx_sh_r    <= 8'h00;
      rx_sh_r    <= 8'h00;
      last_r     <= 1'b0;
      ss_r       <= 1'b1;
      sclk_r     <= SPI_IDLE_SCLK;
      mosi_r     <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      div_r      <= div_nxt_s;
      bit_r      <= bit_nxt_s;
      gap_r      <= gap_nxt_s;
      tx_sh_r    <= tx_sh_nxt_s;
      rx_sh_r    <= rx_sh_nxt_s;
      last_r     <= last_nxt_s;
      ss_r       <= ss_nxt_s;
      sclk_r     <= sclk_nxt_s;
      mosi_r     <= mosi_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_stream_tx.sv
// Directed self-checking bench for spi_stream_tx with CLK_DIV=2, FIFO_DEPTH=16, CS_GAP=2.
module tb_spi_stream_tx;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int CS_GAP     = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;

  int n_checks = 0;
  int n_errors = 0;

  // slave model / monitor state
  int         frames    = 0;
  int         last_low  = 0;
  int         cur_low   = 0;
  int         rx_count  = 0;
  int         rx_at     = 0;
  int         bit_idx   = 0;
  logic [7:0] mosi_byte = 8'h00;
  logic [7:0] rx_pat    = 8'h3C;
  logic       prev_ss   = 1'b1;
  logic       prev_sclk = 1'b1;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  spi_stream_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CS_GAP     (CS_GAP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .ss       (ss),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l, output int waited);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    while (!in_ready && waited < 2000) begin
      tick();
      waited++;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int start = frames;
    int n = 0;
    while (frames == start && n < 3000) begin
      tick();
      n++;
    end
    check(tag, frames - start, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  // SPI slave: records mosi on sclk rises, drives miso from rx_pat, times ss-low windows.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        bit_idx = 0;
        cur_low = 0;
      end else begin
        if (!ss) begin
          cur_low++;
          if (sclk && !prev_sclk) begin
            mosi_byte = {mosi_byte[6:0], mosi};
            bit_idx++;
            if (bit_idx == 8) begin
              tx_q.push_back(mosi_byte);
              bit_idx = 0;
            end
          end
        end else begin
          if (!prev_ss) begin
            last_low = cur_low;
            frames++;
          end
          cur_low = 0;
          bit_idx = 0;
        end
        if (rx_valid) begin
          rx_q.push_back(rx_data);
          rx_count++;
          rx_at = cur_low;
        end
      end
      miso      = rx_pat[7 - bit_idx];
      prev_ss   = ss;
      prev_sclk = sclk;
    end
  end

  initial begin
    int w;
    int n0;
    int r0;
    int sumw;
    logic [7:0] seq [4];
    seq = '{8'h65, 8'h33, 8'h5B, 8'h1B};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; miso = 1'b0;
    repeat (3) tick();
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 1);
    check("rst_mosi", mosi, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    repeat (2) tick();

    // single byte frame, exact ss window and gap
    rx_pat = 8'h3C; n0 = tx_q.size(); r0 = rx_count;
    push(8'h1B, 1'b1, w);
    check("t1_ss_pre", ss, 1);
    check("t1_busy", busy, 1);
    tick();
    check("t1_ss_low", ss, 0);
    wait_frame("t1_frame");
    check("t1_len", last_low, 36);
    check("t1_rx_cnt", rx_count - r0, 1);
    check("t1_mosi", tx_q[n0], 8'h1B);
    check("t1_rx", rx_q[r0], 8'h3C);
    check("t1_rx_at", rx_at, 35);
    tick();
    check("t1_gap_busy", busy, 1);
    tick();
    check("t1_idle_busy", busy, 0);

    // four contiguous bytes in one frame
    wait_idle();
    n0 = tx_q.size(); r0 = rx_count;
    for (int i = 0; i < 4; i++) push(seq[i], (i == 3), w);
    wait_frame("t2_frame");
    check("t2_len", last_low, 132);
    check("t2_rx_cnt", rx_count - r0, 4);
    for (int i = 0; i < 4; i++) check("t2_mosi", tx_q[n0 + i], {24'h0, seq[i]});
    check("t2_rx", rx_q[r0 + 3], 8'h3C);

    // miso capture
    wait_idle();
    rx_pat = 8'hA5; n0 = tx_q.size(); r0 = rx_count;
    push(8'h00, 1'b1, w);
    wait_frame("t3_frame");
    check("t3_rx", rx_q[r0], 8'hA5);
    check("t3_mosi", tx_q[n0], 8'h00);

    // stall between bytes of one frame
    wait_idle();
    n0 = tx_q.size(); r0 = rx_count;
    push(8'h41, 1'b0, w);
    repeat (60) tick();
    check("t4_stall_ss", ss, 0);
    check("t4_stall_sclk", sclk, 1);
    check("t4_stall_mosi", mosi, 1);
    check("t4_stall_busy", busy, 1);
    repeat (40) tick();
    push(8'h42, 1'b1, w);
    wait_frame("t4_frame");
    check("t4_len", last_low, 137);
    check("t4_mosi0", tx_q[n0], 8'h41);
    check("t4_mosi1", tx_q[n0 + 1], 8'h42);
    check("t4_rx_cnt", rx_count - r0, 2);

    // FIFO fill to full; blocked write admitted only after the next pop
    wait_idle();
    n0 = tx_q.size(); r0 = rx_count; sumw = 0;
    for (int k = 0; k < 17; k++) begin
      push(8'(k), 1'b0, w);
      sumw += w;
    end
    check("t5_fill_wait", sumw, 0);
    check("t5_full", in_ready, 0);
    push(8'hEE, 1'b1, w);
    check("t5_hold_wait", w, 19);
    wait_frame("t5_frame");
    check("t5_len", last_low, 580);
    check("t5_rx_cnt", rx_count - r0, 18);
    check("t5_mosi_first", tx_q[n0], 8'h00);
    check("t5_mosi_16", tx_q[n0 + 16], 8'h10);
    check("t5_mosi_last", tx_q[n0 + 17], 8'hEE);

    // reset in the middle of a byte, then a clean frame
    wait_idle();
    r0 = rx_count;
    push(8'hC3, 1'b1, w);
    repeat (7) tick();
    check("t6_pre_sclk", sclk, 0);
    check("t6_pre_mosi", mosi, 1);
    reset = 1'b1;
    tick();
    check("t6_ss", ss, 1);
    check("t6_sclk", sclk, 1);
    check("t6_mosi", mosi, 0);
    check("t6_busy", busy, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_in_ready", in_ready, 1);
    reset = 1'b0;
    repeat (3) tick();
    check("t6_no_rx", rx_count - r0, 0);
    rx_pat = 8'h96; n0 = tx_q.size(); r0 = rx_count;
    push(8'h5A, 1'b1, w);
    wait_frame("t6_frame");
    check("t6_len", last_low, 36);
    check("t6_mosi", tx_q[n0], 8'h5A);
    check("t6_rx", rx_q[r0], 8'h96);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
